// File: rtl/ddr2_ui_responder.sv
// Stand-in for the DDR2 controller user interface: queues commands and write data,
// stores words in an on-chip RAM and returns two-beat read bursts after a fixed latency.
module ddr2_ui_responder #(
    parameter int DATA_WIDTH   = 64,
    parameter int MEM_AW       = 10,
    parameter int AF_DEPTH     = 16,
    parameter int DF_DEPTH     = 32,
    parameter int AFULL_MARGIN = 4,
    parameter int READ_LATENCY = 4,
    parameter int CAL_CYCLES   = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      ddr_rd_wr_n_i,
    input  logic [30:0]               ddr_addr_i,
    input  logic                      ddr_af_we_i,
    input  logic [2*DATA_WIDTH-1:0]   ddr_data_i,
    input  logic [2*DATA_WIDTH/8-1:0] ddr_mask_n_i,
    input  logic                      ddr_df_we_i,
    output logic                      ddr_af_afull_o,
    output logic                      ddr_df_afull_o,
    output logic [2*DATA_WIDTH-1:0]   ddr_data_o,
    output logic                      ddr_dvalid_o,
    output logic                      ddr_phy_rdy_o,
    output logic [1:0]                ovf_o
);
    localparam int UW     = 2 * DATA_WIDTH;
    localparam int MW     = UW / 8;
    localparam int CA     = MEM_AW - 1;
    localparam int AF_AW  = $clog2(AF_DEPTH);
    localparam int DF_AW  = $clog2(DF_DEPTH);
    localparam int AF_CW  = AF_AW + 1;
    localparam int DF_CW  = DF_AW + 1;
    localparam int CAL_W  = $clog2(CAL_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR0  = 3'd1,
        ST_WR1  = 3'd2,
        ST_RD0  = 3'd3,
        ST_RD1  = 3'd4
    } state_t;

    logic [CAL_W-1:0] r_cal_cnt;
    logic             r_phy_rdy;
    logic             r_af_rw   [AF_DEPTH];
    logic [CA-1:0]    r_af_addr [AF_DEPTH];
    logic [AF_CW-1:0] r_af_wptr, r_af_rptr;
    logic             r_af_afull;
    logic [UW-1:0]    r_df_data [DF_DEPTH];
    logic [MW-1:0]    r_df_mask [DF_DEPTH];
    logic [DF_CW-1:0] r_df_wptr, r_df_rptr;
    logic             r_df_afull;
    logic [1:0]       r_ovf;
    state_t           r_state;
    logic [CA-1:0]    r_cmd_addr;
    logic [UW-1:0]    r_mem [2**MEM_AW];
    logic             r_pipe_vld  [READ_LATENCY];
    logic [UW-1:0]    r_pipe_data [READ_LATENCY];

    logic [AF_CW-1:0] w_af_cnt, w_af_cnt_nxt;
    logic [DF_CW-1:0] w_df_cnt, w_df_cnt_nxt;
    logic             w_af_empty, w_af_full, w_af_push, w_af_acc, w_af_pop;
    logic             w_df_empty, w_df_full, w_df_push, w_df_acc, w_df_pop;
    logic             w_mem_we, w_rd_issue, w_beat;
    logic [MEM_AW-1:0] w_word_addr;
    logic             w_af_head_rw;
    logic [CA-1:0]    w_af_head_addr;
    logic [UW-1:0]    w_df_head_data;
    logic [MW-1:0]    w_df_head_mask;
    logic             w_unused_addr;

    assign w_unused_addr  = ^{ddr_addr_i[30:MEM_AW+1], ddr_addr_i[1:0]};
    assign w_af_cnt       = r_af_wptr - r_af_rptr;
    assign w_df_cnt       = r_df_wptr - r_df_rptr;
    assign w_af_empty     = (w_af_cnt == {AF_CW{1'b0}});
    assign w_df_empty     = (w_df_cnt == {DF_CW{1'b0}});
    assign w_af_full      = (w_af_cnt == AF_CW'(AF_DEPTH));
    assign w_df_full      = (w_df_cnt == DF_CW'(DF_DEPTH));
    assign w_af_push      = ddr_af_we_i & r_phy_rdy;
    assign w_df_push      = ddr_df_we_i & r_phy_rdy;
    // A full FIFO still accepts a push when it is being popped in the same cycle.
    assign w_af_acc       = w_af_push & (~w_af_full | w_af_pop);
    assign w_df_acc       = w_df_push & (~w_df_full | w_df_pop);
    assign w_af_cnt_nxt   = w_af_cnt + {{AF_AW{1'b0}}, w_af_acc} - {{AF_AW{1'b0}}, w_af_pop};
    assign w_df_cnt_nxt   = w_df_cnt + {{DF_AW{1'b0}}, w_df_acc} - {{DF_AW{1'b0}}, w_df_pop};
    assign w_af_head_rw   = r_af_rw[r_af_rptr[AF_AW-1:0]];
    assign w_af_head_addr = r_af_addr[r_af_rptr[AF_AW-1:0]];
    assign w_df_head_data = r_df_data[r_df_rptr[DF_AW-1:0]];
    assign w_df_head_mask = r_df_mask[r_df_rptr[DF_AW-1:0]];
    assign w_beat         = (r_state == ST_WR1) || (r_state == ST_RD1);
    assign w_word_addr    = {r_cmd_addr, w_beat};

    assign ddr_af_afull_o = r_af_afull;
    assign ddr_df_afull_o = r_df_afull;
    assign ddr_phy_rdy_o  = r_phy_rdy;
    assign ovf_o          = r_ovf;
    assign ddr_dvalid_o   = r_pipe_vld[READ_LATENCY-1];
    assign ddr_data_o     = r_pipe_data[READ_LATENCY-1];

    // Calibration emulation: ready rises CAL_CYCLES clocks after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cal_cnt <= {CAL_W{1'b0}};
            r_phy_rdy <= 1'b0;
        end else if (!r_phy_rdy) begin
            r_cal_cnt <= r_cal_cnt + CAL_W'(1);
            r_phy_rdy <= (r_cal_cnt == CAL_W'(CAL_CYCLES - 1));
        end
    end

    // FIFO storage (not reset, only read when the pointers say it is valid).
    always_ff @(posedge clk) begin
        if (w_af_acc) begin
            r_af_rw[r_af_wptr[AF_AW-1:0]]   <= ddr_rd_wr_n_i;
            r_af_addr[r_af_wptr[AF_AW-1:0]] <= ddr_addr_i[MEM_AW:2];
        end
        if (w_df_acc) begin
            r_df_data[r_df_wptr[DF_AW-1:0]] <= ddr_data_i;
            r_df_mask[r_df_wptr[DF_AW-1:0]] <= ddr_mask_n_i;
        end
    end

    // FIFO pointers, registered almost-full flags and sticky overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_af_wptr  <= {AF_CW{1'b0}};
            r_af_rptr  <= {AF_CW{1'b0}};
            r_df_wptr  <= {DF_CW{1'b0}};
            r_df_rptr  <= {DF_CW{1'b0}};
            r_af_afull <= 1'b0;
            r_df_afull <= 1'b0;
            r_ovf      <= 2'b00;
        end else begin
            if (w_af_acc) r_af_wptr <= r_af_wptr + AF_CW'(1);
            if (w_af_pop) r_af_rptr <= r_af_rptr + AF_CW'(1);
            if (w_df_acc) r_df_wptr <= r_df_wptr + DF_CW'(1);
            if (w_df_pop) r_df_rptr <= r_df_rptr + DF_CW'(1);
            r_af_afull <= (w_af_cnt_nxt >= AF_CW'(AF_DEPTH - AFULL_MARGIN));
            r_df_afull <= (w_df_cnt_nxt >= DF_CW'(DF_DEPTH - AFULL_MARGIN));
            if (w_af_push && !w_af_acc) r_ovf[0] <= 1'b1;
            if (w_df_push && !w_df_acc) r_ovf[1] <= 1'b1;
        end
    end

    // FIFO pops, RAM write enable and read issue decoded from the current state.
    always_comb begin
        w_af_pop   = 1'b0;
        w_df_pop   = 1'b0;
        w_mem_we   = 1'b0;
        w_rd_issue = 1'b0;
        case (r_state)
            ST_IDLE: w_af_pop = ~w_af_empty;
            ST_WR0: begin
                w_df_pop = ~w_df_empty;
                w_mem_we = ~w_df_empty;
            end
            ST_WR1: begin
                w_df_pop = ~w_df_empty;
                w_mem_we = ~w_df_empty;
                w_af_pop = ~w_df_empty & ~w_af_empty;
            end
            ST_RD0: w_rd_issue = 1'b1;
            ST_RD1: begin
                w_rd_issue = 1'b1;
                w_af_pop   = ~w_af_empty;
            end
            default: w_af_pop = 1'b0;
        endcase
    end

    // Command sequencer; the last beat of a command chains straight into the next one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cmd_addr <= {CA{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE, ST_RD1: begin
                    if (w_af_pop) begin
                        r_cmd_addr <= w_af_head_addr;
                        r_state    <= w_af_head_rw ? ST_RD0 : ST_WR0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WR0: if (!w_df_empty) r_state <= ST_WR1;
                ST_WR1: begin
                    if (w_af_pop) begin
                        r_cmd_addr <= w_af_head_addr;
                        r_state    <= w_af_head_rw ? ST_RD0 : ST_WR0;
                    end else if (!w_df_empty) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RD0:  r_state <= ST_RD1;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Backing RAM with active-low byte write mask.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < MW; i++) begin
                if (!w_df_head_mask[i]) r_mem[w_word_addr][8*i +: 8] <= w_df_head_data[8*i +: 8];
            end
        end
    end

    // Read return delay line; stage 0 is the synchronous RAM read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_vld[i]  <= 1'b0;
                r_pipe_data[i] <= {UW{1'b0}};
            end
        end else begin
            r_pipe_vld[0]  <= w_rd_issue;
            r_pipe_data[0] <= w_rd_issue ? r_mem[w_word_addr] : {UW{1'b0}};
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_data[i] <= r_pipe_data[i-1];
            end
        end
    end
endmodule

// File: tb/tb_ddr2_ui_responder.sv
// Directed bench for ddr2_ui_responder: calibration, write/read bursts, byte masks,
// aliasing, FIFO almost-full/overflow and reset during a read burst.
module tb_ddr2_ui_responder;
    logic          clk;
    logic          reset_n;
    logic          ddr_rd_wr_n_i;
    logic [30:0]   ddr_addr_i;
    logic          ddr_af_we_i;
    logic [127:0]  ddr_data_i;
    logic [15:0]   ddr_mask_n_i;
    logic          ddr_df_we_i;
    logic          ddr_af_afull_o;
    logic          ddr_df_afull_o;
    logic [127:0]  ddr_data_o;
    logic          ddr_dvalid_o;
    logic          ddr_phy_rdy_o;
    logic [1:0]    ovf_o;

    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc   = 0;
    int            p0;
    logic [127:0]  q_data[$];
    int            q_cyc[$];
    logic [127:0]  exp_beats[4];

    localparam logic [127:0] A0 = 128'hA0A0_0000_1111_2222_3333_4444_5555_0A00;
    localparam logic [127:0] A1 = 128'hA1A1_6666_7777_8888_9999_AAAA_BBBB_0A01;
    localparam logic [127:0] B0 = 128'hB0B0_CCCC_DDDD_EEEE_FFFF_0123_4567_0B00;
    localparam logic [127:0] B1 = 128'hB1B1_89AB_CDEF_FEDC_BA98_7654_3210_0B01;
    localparam logic [127:0] C0 = 128'hC0C0_0000_0000_0000_0000_0000_0000_0C00;
    localparam logic [127:0] C1 = 128'hC1C1_0000_0000_0000_0000_0000_0000_0C01;
    localparam logic [127:0] D0 = 128'hD0D0_1234_5678_9ABC_DEF0_1357_9BDF_0D00;
    localparam logic [127:0] D1 = 128'hD1D1_2468_ACE0_1122_3344_5566_7788_0D01;
    localparam logic [127:0] E0 = 128'hE0E0_0F0F_F0F0_0F0F_F0F0_0F0F_F0F0_0E00;
    localparam logic [127:0] E1 = 128'hE1E1_5A5A_A5A5_5A5A_A5A5_5A5A_A5A5_0E01;
    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] LOW0 = {{120{1'b1}}, 8'h00};

    ddr2_ui_responder dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ddr_rd_wr_n_i  (ddr_rd_wr_n_i),
        .ddr_addr_i     (ddr_addr_i),
        .ddr_af_we_i    (ddr_af_we_i),
        .ddr_data_i     (ddr_data_i),
        .ddr_mask_n_i   (ddr_mask_n_i),
        .ddr_df_we_i    (ddr_df_we_i),
        .ddr_af_afull_o (ddr_af_afull_o),
        .ddr_df_afull_o (ddr_df_afull_o),
        .ddr_data_o     (ddr_data_o),
        .ddr_dvalid_o   (ddr_dvalid_o),
        .ddr_phy_rdy_o  (ddr_phy_rdy_o),
        .ovf_o          (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to time read returns.
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every returned beat with the edge count at which it appeared.
    always @(negedge clk) begin
        if (ddr_dvalid_o) begin
            q_data.push_back(ddr_data_o);
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_cmd(input logic rd, input logic [30:0] addr);
        ddr_rd_wr_n_i = rd;
        ddr_addr_i    = addr;
        ddr_af_we_i   = 1'b1;
        tick(1);
        ddr_af_we_i   = 1'b0;
    endtask

    task automatic push_data(input logic [127:0] d, input logic [15:0] m);
        ddr_data_i   = d;
        ddr_mask_n_i = m;
        ddr_df_we_i  = 1'b1;
        tick(1);
        ddr_df_we_i  = 1'b0;
    endtask

    task automatic clear_q();
        q_data.delete();
        q_cyc.delete();
    endtask

    initial begin
        reset_n       = 1'b0;
        ddr_rd_wr_n_i = 1'b0;
        ddr_addr_i    = 31'h0;
        ddr_af_we_i   = 1'b0;
        ddr_data_i    = 128'h0;
        ddr_mask_n_i  = 16'h0;
        ddr_df_we_i   = 1'b0;
        tick(3);
        check_eq("rst_dvalid", 128'(ddr_dvalid_o), 128'h0);
        check_eq("rst_rdy",    128'(ddr_phy_rdy_o), 128'h0);
        check_eq("rst_ovf",    128'(ovf_o), 128'h0);
        check_eq("rst_afull",  128'({ddr_af_afull_o, ddr_df_afull_o}), 128'h0);
        check_eq("rst_data",   ddr_data_o, 128'h0);

        // Calibration window; a read pushed while not ready must vanish.
        reset_n = 1'b1;
        tick(10);
        push_cmd(1'b1, 31'h0);
        tick(52);
        check_eq("cal_rdy_63", 128'(ddr_phy_rdy_o), 128'h0);
        tick(1);
        check_eq("cal_rdy_64", 128'(ddr_phy_rdy_o), 128'h1);
        tick(12);
        check_eq("cal_ignored_beats", 128'(q_data.size()), 128'h0);
        check_eq("cal_ignored_ovf", 128'(ovf_o), 128'h0);

        // Two writes then back-to-back reads: four contiguous beats.
        push_cmd(1'b0, 31'h0); push_data(A0, 16'h0); push_data(A1, 16'h0);
        push_cmd(1'b0, 31'h4); push_data(B0, 16'h0); push_data(B1, 16'h0);
        tick(8);
        clear_q();
        p0 = cyc;
        push_cmd(1'b1, 31'h0);
        push_cmd(1'b1, 31'h4);
        tick(12);
        exp_beats[0] = A0; exp_beats[1] = A1; exp_beats[2] = B0; exp_beats[3] = B1;
        check_eq("rd_nbeats", 128'(q_data.size()), 128'h4);
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            check_eq($sformatf("rd_beat%0d", i), q_data[i], exp_beats[i]);
            check_eq($sformatf("rd_cyc%0d", i), 128'(q_cyc[i]), 128'(p0 + 6 + i));
        end

        // Byte mask: only byte 0 overwritten with zeros.
        push_cmd(1'b0, 31'h8); push_data(ONES, 16'h0); push_data(ONES, 16'h0);
        push_cmd(1'b0, 31'h8); push_data(128'h0, 16'hFFFE); push_data(128'h0, 16'hFFFE);
        tick(8);
        clear_q();
        push_cmd(1'b1, 31'h8);
        tick(12);
        check_eq("mask_nbeats", 128'(q_data.size()), 128'h2);
        if (q_data.size() >= 2) begin
            check_eq("mask_beat0", q_data[0], LOW0);
            check_eq("mask_beat1", q_data[1], LOW0);
        end

        // Address aliasing above the RAM size.
        push_cmd(1'b0, 31'h0);   push_data(C0, 16'h0); push_data(C1, 16'h0);
        push_cmd(1'b0, 31'h800); push_data(D0, 16'h0); push_data(D1, 16'h0);
        tick(8);
        clear_q();
        push_cmd(1'b1, 31'h0);
        tick(12);
        check_eq("alias_nbeats", 128'(q_data.size()), 128'h2);
        if (q_data.size() >= 2) begin
            check_eq("alias_beat0", q_data[0], D0);
            check_eq("alias_beat1", q_data[1], D1);
        end

        // Address FIFO fill behind a data-less write.
        clear_q();
        push_cmd(1'b0, 31'h10);
        tick(4);
        for (int i = 1; i <= 17; i++) begin
            push_cmd(1'b1, 31'h0);
            if (i == 11) check_eq("af_afull_11", 128'(ddr_af_afull_o), 128'h0);
            if (i == 12) check_eq("af_afull_12", 128'(ddr_af_afull_o), 128'h1);
            if (i == 16) check_eq("af_ovf_16", 128'(ovf_o), 128'h0);
            if (i == 17) check_eq("af_ovf_17", 128'(ovf_o), 128'h1);
        end
        check_eq("af_stall_beats", 128'(q_data.size()), 128'h0);
        push_data(E0, 16'h0);
        push_data(E1, 16'h0);
        tick(60);
        check_eq("af_kept_beats", 128'(q_data.size()), 128'd32);
        if (q_data.size() >= 32) begin
            check_eq("af_first_beat", q_data[0], D0);
            check_eq("af_last_beat", q_data[31], D1);
        end
        check_eq("af_afull_drain", 128'(ddr_af_afull_o), 128'h0);
        clear_q();
        push_cmd(1'b1, 31'h10);
        tick(12);
        check_eq("stall_wr_nbeats", 128'(q_data.size()), 128'h2);
        if (q_data.size() >= 2) begin
            check_eq("stall_wr_beat0", q_data[0], E0);
            check_eq("stall_wr_beat1", q_data[1], E1);
        end

        // Data FIFO fill while the sequencer is idle.
        for (int i = 1; i <= 33; i++) begin
            push_data(128'(i), 16'hFFFF);
            if (i == 27) check_eq("df_afull_27", 128'(ddr_df_afull_o), 128'h0);
            if (i == 28) check_eq("df_afull_28", 128'(ddr_df_afull_o), 128'h1);
            if (i == 32) check_eq("df_ovf_32", 128'(ovf_o), 128'h1);
            if (i == 33) check_eq("df_ovf_33", 128'(ovf_o), 128'h3);
        end

        // Reset asserted while beat 0 of a read is on the bus.
        clear_q();
        push_cmd(1'b1, 31'h0);
        begin
            int waited;
            waited = 0;
            while (!ddr_dvalid_o && waited < 20) begin
                tick(1);
                waited++;
            end
            check_eq("rst6_beat_seen", 128'(ddr_dvalid_o), 128'h1);
        end
        reset_n = 1'b0;
        #1;
        check_eq("rst6_dvalid_drop", 128'(ddr_dvalid_o), 128'h0);
        check_eq("rst6_ovf_clear", 128'(ovf_o), 128'h0);
        check_eq("rst6_df_afull", 128'(ddr_df_afull_o), 128'h0);
        tick(3);
        reset_n = 1'b1;
        clear_q();
        tick(63);
        check_eq("rst6_rdy_63", 128'(ddr_phy_rdy_o), 128'h0);
        tick(1);
        check_eq("rst6_rdy_64", 128'(ddr_phy_rdy_o), 128'h1);
        tick(10);
        check_eq("rst6_no_stray", 128'(q_data.size()), 128'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
